// File: rtl/ex2_stage.sv
// ex2_stage: second execute stage -- 16-bit ALU feeding the EX/MEM pipeline register.
// Build option EX2_MUL_EN adds an iterative shift-add multiplier for op 11; without it op 11 yields 0.
module ex2_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_alu_op,
    input  logic [15:0] alu_in1,
    input  logic [15:0] alu_in2,
    input  logic [15:0] ex_store_data,
    input  logic [2:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        flush,
    input  logic        mem_stall,
    output logic        ex_busy,
    output logic        exmem_valid,
    output logic [15:0] exmem_alu_result,
    output logic [15:0] exmem_store_data,
    output logic [2:0]  exmem_rd,
    output logic        exmem_reg_write,
    output logic        exmem_mem_read,
    output logic        exmem_mem_write,
    output logic        exmem_zero,
    output logic [1:0]  dbg_state_o
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    // Handshake: the ID/EX instruction is consumed at an edge where ex_busy=0 and mem_stall=0,
    // or killed by flush=1; ex_busy holds ID/EX while a multiply is being started or iterated.

    logic [15:0] alu_res;
    logic [3:0]  shamt;

    assign shamt = alu_in2[3:0];

    always_comb begin
        alu_res = 16'h0000;
        case (ex_alu_op)
            OP_ADD:   alu_res = alu_in1 + alu_in2;
            OP_SUB:   alu_res = alu_in1 - alu_in2;
            OP_AND:   alu_res = alu_in1 & alu_in2;
            OP_OR:    alu_res = alu_in1 | alu_in2;
            OP_XOR:   alu_res = alu_in1 ^ alu_in2;
            OP_SLL:   alu_res = alu_in1 << shamt;
            OP_SRL:   alu_res = alu_in1 >> shamt;
            OP_SRA:   alu_res = $signed(alu_in1) >>> shamt;
            OP_SLT:   alu_res = {15'd0, $signed(alu_in1) < $signed(alu_in2)};
            OP_SLTU:  alu_res = {15'd0, alu_in1 < alu_in2};
            OP_PASSB: alu_res = alu_in2;
            default:  alu_res = 16'h0000;
        endcase
    end

    logic        mul_load;
    logic [15:0] mul_res;

`ifdef EX2_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] mcand_q;
    logic [15:0] mplier_q;
    logic [15:0] prod_q;
    logic [3:0]  cnt_q;
    logic        mul_start;

    assign mul_start = (state_q == S_IDLE) && ex_valid && (ex_alu_op == OP_MUL);

    // Multiplicand shifts left and multiplier right, so only the low 16 product bits are kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
            prod_q   <= 16'h0000;
            cnt_q    <= 4'd0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mul_start) begin
                        mcand_q  <= alu_in1;
                        mplier_q <= alu_in2;
                        prod_q   <= 16'h0000;
                        cnt_q    <= 4'd0;
                        state_q  <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!mem_stall) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ex_busy     = mul_start || (state_q == S_MUL);
    assign mul_load    = (state_q == S_DONE);
    assign mul_res     = prod_q;
    assign dbg_state_o = state_q;
`else
    assign ex_busy     = 1'b0;
    assign mul_load    = 1'b0;
    assign mul_res     = 16'h0000;
    assign dbg_state_o = 2'b00;
`endif

    logic        valid_q, valid_d;
    logic        rw_q, rw_d;
    logic        mr_q, mr_d;
    logic        mw_q, mw_d;
    logic        zero_q, zero_d;
    logic [15:0] result_q, result_d;
    logic [15:0] store_q, store_d;
    logic [2:0]  rd_q, rd_d;
    logic [15:0] load_res;

    assign load_res = mul_load ? mul_res : alu_res;

    // Bubbles clear only the valid/control bits; data fields keep their last value.
    always_comb begin
        valid_d  = valid_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        zero_d   = zero_q;
        result_d = result_q;
        store_d  = store_q;
        rd_d     = rd_q;
        if (flush) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
        end else if (!mem_stall) begin
            if (mul_load || (ex_valid && !ex_busy)) begin
                valid_d  = 1'b1;
                result_d = load_res;
                zero_d   = (load_res == 16'h0000);
                store_d  = ex_store_data;
                rd_d     = ex_rd;
                rw_d     = ex_reg_write;
                mr_d     = ex_mem_read;
                mw_d     = ex_mem_write;
            end else begin
                valid_d = 1'b0;
                rw_d    = 1'b0;
                mr_d    = 1'b0;
                mw_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= 16'h0000;
            store_q  <= 16'h0000;
            rd_q     <= 3'd0;
        end else begin
            valid_q  <= valid_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
        end
    end

    assign exmem_valid      = valid_q;
    assign exmem_reg_write  = rw_q;
    assign exmem_mem_read   = mr_q;
    assign exmem_mem_write  = mw_q;
    assign exmem_zero       = zero_q;
    assign exmem_alu_result = result_q;
    assign exmem_store_data = store_q;
    assign exmem_rd         = rd_q;

endmodule

// File: tb/tb_ex2_stage.sv
// tb_ex2_stage: randomized and directed stimulus for ex2_stage, checked by a queue scoreboard.
// Works with or without EX2_MUL_EN defined.
`timescale 1ns/1ps
module tb_ex2_stage;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd11;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, flush, mem_stall;
    logic [3:0]  ex_alu_op;
    logic [15:0] alu_in1, alu_in2, ex_store_data;
    logic [2:0]  ex_rd;
    logic        ex_busy, exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_zero;
    logic [15:0] exmem_alu_result, exmem_store_data;
    logic [2:0]  exmem_rd;
    logic [1:0]  dbg_state_o;

    ex2_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .flush(flush), .mem_stall(mem_stall),
        .ex_busy(ex_busy), .exmem_valid(exmem_valid), .exmem_alu_result(exmem_alu_result),
        .exmem_store_data(exmem_store_data), .exmem_rd(exmem_rd),
        .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .exmem_mem_write(exmem_mem_write), .exmem_zero(exmem_zero), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] sd;
        logic [2:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        zero;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cyc = 0;
    logic        stall_at_edge = 1'b0;

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        stall_at_edge <= mem_stall;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each op computed in 32-bit arithmetic, low 16 bits kept.
    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        int          sa, sb, sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[3:0];
        r  = 32'd0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = sa >>> sh;
            4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: r = b;
`ifdef EX2_MUL_EN
            4'd11: r = a * b;
`endif
            default: r = 32'd0;
        endcase
        return r[15:0];
    endfunction

    // Monitor: a new result is on exmem only after an edge that was not stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst && exmem_valid && !stall_at_edge) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", exmem_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result",    exmem_alu_result, e.res);
                chk("zero",      exmem_zero,       e.zero);
                chk("store",     exmem_store_data, e.sd);
                chk("rd",        exmem_rd,         e.rd);
                chk("reg_write", exmem_reg_write,  e.rw);
                chk("mem_read",  exmem_mem_read,   e.mr);
                chk("mem_write", exmem_mem_write,  e.mw);
                chk("latency",   cyc,              e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        ex_valid      = 1'b1;
        ex_alu_op     = op;
        alu_in1       = a;
        alu_in2       = b;
        ex_store_data = 16'($urandom);
        ex_rd         = 3'($urandom_range(0, 7));
        ex_reg_write  = 1'($urandom_range(0, 1));
        ex_mem_read   = 1'($urandom_range(0, 1));
        ex_mem_write  = 1'($urandom_range(0, 1));
    endtask

    task automatic push_exp(input logic [15:0] res, input int lat);
        exp_t e;
        e.res  = res;
        e.zero = (res == 16'h0000);
        e.sd   = ex_store_data;
        e.rd   = ex_rd;
        e.rw   = ex_reg_write;
        e.mr   = ex_mem_read;
        e.mw   = ex_mem_write;
        e.cyc  = cyc + 32'(lat);
        exp_q.push_back(e);
    endtask

    // Single-cycle op, optionally held by nstall stalled edges before it is accepted.
    task automatic issue_gen(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input int nstall, input logic [15:0] exp_res);
        present(op, a, b);
        push_exp(exp_res, nstall + 1);
        #1 chk("busy_single", ex_busy, 0);
        for (int i = 0; i < nstall; i++) begin
            mem_stall = 1'b1;
            step();
        end
        mem_stall = 1'b0;
        step();
        ex_valid = 1'b0;
    endtask

    task automatic issue_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int nstall);
        issue_gen(op, a, b, nstall, ref_alu(op, a, b));
    endtask

    task automatic issue_mul(input logic [15:0] a, input logic [15:0] b, input int nstall,
                             input logic [15:0] exp_res);
`ifdef EX2_MUL_EN
        present(OP_MUL, a, b);
        push_exp(exp_res, 18 + nstall);
        #1 chk("busy_mul_start", ex_busy, 1);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("busy_mul_iter", ex_busy, 1);
            chk("valid_mul_iter", exmem_valid, 0);
            alu_in1 = 16'($urandom);
            alu_in2 = 16'($urandom);
        end
        step();
        chk("busy_done", ex_busy, 0);
        chk("state_done", dbg_state_o, 2);
        chk("valid_done", exmem_valid, 0);
        for (int s = 0; s < nstall; s++) begin
            mem_stall = 1'b1;
            step();
            chk("stall_hold_valid", exmem_valid, 0);
            chk("stall_hold_busy", ex_busy, 0);
        end
        mem_stall = 1'b0;
        step();
        ex_valid = 1'b0;
`else
        issue_gen(OP_MUL, a, b, nstall, exp_res);
`endif
    endtask

    function automatic logic [15:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b;
        rst = 1'b1;
        ex_valid = 1'b0; ex_alu_op = 4'd0; alu_in1 = 16'h0; alu_in2 = 16'h0; ex_store_data = 16'h0;
        ex_rd = 3'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        flush = 1'b0; mem_stall = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("reset_valid", exmem_valid, 0);
        chk("reset_result", exmem_alu_result, 0);
        chk("reset_zero", exmem_zero, 0);
        chk("reset_busy", ex_busy, 0);
        chk("reset_state", dbg_state_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();

        issue_gen(OP_ADD, 16'h7FFF, 16'h0001, 0, 16'h8000);
        issue_gen(OP_SUB, 16'h0005, 16'h0005, 0, 16'h0000);
        issue_gen(OP_SRA, 16'h8000, 16'h0004, 0, 16'hF800);
        issue_gen(OP_SLT, 16'hFFFF, 16'h0001, 0, 16'h0001);
        issue_gen(OP_SLTU, 16'hFFFF, 16'h0001, 0, 16'h0000);

`ifdef EX2_MUL_EN
        issue_mul(16'h0123, 16'h0010, 0, 16'h1230);
        issue_mul(16'hABCD, 16'h1234, 3, ref_alu(OP_MUL, 16'hABCD, 16'h1234));
`else
        issue_mul(16'h0123, 16'h0010, 0, 16'h0000);
        issue_mul(16'hABCD, 16'h1234, 3, 16'h0000);
`endif

        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = rand_opnd();
            b  = rand_opnd();
            if (op == OP_MUL) begin
                if ($urandom_range(0, 2) == 0) issue_mul(a, b, $urandom_range(0, 2), ref_alu(OP_MUL, a, b));
            end else begin
                issue_alu(op, a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            end
            if ($urandom_range(0, 4) == 0) begin
                ex_valid = 1'b0;
                step();
            end
        end

        // Flush outranks a stall: the held valid result is replaced by a bubble.
        issue_alu(OP_ADD, 16'h0001, 16'h0002, 0);
        present(OP_XOR, 16'h1111, 16'h2222);
        flush = 1'b1;
        mem_stall = 1'b1;
        step();
        flush = 1'b0;
        mem_stall = 1'b0;
        ex_valid = 1'b0;
        chk("flush_valid", exmem_valid, 0);
        chk("flush_reg_write", exmem_reg_write, 0);
        chk("flush_mem_read", exmem_mem_read, 0);
        chk("flush_mem_write", exmem_mem_write, 0);

`ifdef EX2_MUL_EN
        present(OP_MUL, 16'h00FF, 16'h0101);
        repeat (9) step();
        chk("flush_pre_state", dbg_state_o, 1);
        flush = 1'b1;
        ex_valid = 1'b0;
        mem_stall = 1'b1;
        #1 chk("flush_pre_busy", ex_busy, 1);
        step();
        flush = 1'b0;
        mem_stall = 1'b0;
        #1;
        chk("flush_mul_busy", ex_busy, 0);
        chk("flush_mul_state", dbg_state_o, 0);
        chk("flush_mul_valid", exmem_valid, 0);
        repeat (20) step();
`endif
        issue_alu(OP_ADD, 16'h1234, 16'h1111, 0);

        // Asynchronous reset in the middle of a multiply.
        issue_alu(OP_OR, 16'h00F0, 16'h0F00, 0);
        present(OP_MUL, 16'h1234, 16'h0055);
`ifdef EX2_MUL_EN
        repeat (6) step();
`endif
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", exmem_valid, 0);
        chk("arst_result", exmem_alu_result, 0);
        chk("arst_store", exmem_store_data, 0);
        chk("arst_rd", exmem_rd, 0);
        chk("arst_reg_write", exmem_reg_write, 0);
        chk("arst_mem_read", exmem_mem_read, 0);
        chk("arst_mem_write", exmem_mem_write, 0);
        chk("arst_zero", exmem_zero, 0);
        chk("arst_state", dbg_state_o, 0);
`ifdef EX2_MUL_EN
        chk("arst_busy_idle_term", ex_busy, 1);
`else
        chk("arst_busy_idle_term", ex_busy, 0);
`endif
        ex_valid = 1'b0;
        #1 chk("arst_busy_clear", ex_busy, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        issue_alu(OP_SUB, 16'h0000, 16'h0001, 0);

        repeat (5) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
